// File: rtl/tl45_regfile_mp.sv
// Multi-read-port register file: entry 0 reads as zero, registered reads, byte-masked write,
// and a post-reset clear sequencer. Define TL45_REGFILE_BYPASS_EN for write-first same-edge reads.
module tl45_regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [1:DEPTH-1];
    logic [DATA_W-1:0] rd_word [NUM_RD];
    logic              wr_fire;

    assign wr_fire = (state == READY) && wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= ADDR_W'(1);
            ready   <= 1'b0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
            if (clr_ptr == LAST_ADDR) begin
                state <= READY;
                ready <= 1'b1;
            end
        end
    end

    // Storage has no reset; the sequencer zeroes one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_fire) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_word[p] = '0;
            if (rd_addr[p*ADDR_W +: ADDR_W] != '0) begin
                rd_word[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef TL45_REGFILE_BYPASS_EN
                if (wr_fire && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
                    for (int unsigned b = 0; b < NB; b++) begin
                        if (wr_be[b]) rd_word[p][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) begin
                    rd_data[p*DATA_W +: DATA_W] <= (state == CLEAR) ? '0 : rd_word[p];
                end
            end
        end
    end

endmodule
